// File: rtl/sha_msg_pad.sv
// SHA-256 message padder: packs 32-bit big-endian words into padded 512-bit blocks (word 0 in the top bits of blk_lo).
// Latency: blk_vld rises the cycle after the accept that completes a block; a trailing length block follows one build cycle after blk_rdy.
// Backpressure: in_rdy is low while a block is presented; the block is held stable until blk_rdy.
module sha_msg_pad #(
    parameter int LEN_W = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_vld,
    output logic         in_rdy,
    input  logic [31:0]  in_data,
    input  logic [2:0]   in_nbytes,
    input  logic         in_last,
    output logic         blk_vld,
    input  logic         blk_rdy,
    output logic [255:0] blk_lo,
    output logic [255:0] blk_hi,
    output logic         blk_first,
    output logic         blk_final
);

    typedef enum logic [1:0] {FILL, EMIT, EXTRA} state_t;

    state_t           state_q, state_d;
    logic [31:0]      blk_q [16];
    logic [3:0]       widx_q;
    logic [LEN_W-1:0] bitlen_q;
    logic             first_q;
    logic             final_q;
    logic             extra_pend_q;
    logic             x80_pend_q;
    logic             built_q;
    logic             run_q;

    logic             accept;
    logic             blk_take;
    logic [2:0]       nb_eff;
    logic [31:0]      byte_mask;
    logic [31:0]      marker;
    logic [31:0]      word_wr;
    logic [LEN_W-1:0] bitlen_nx;
    logic [63:0]      len_nx;
    logic [63:0]      len_cur;
    logic [4:0]       p_idx;

    assign in_rdy    = run_q & (state_q == FILL);
    assign accept    = in_vld & in_rdy;
    assign blk_vld   = (state_q == EMIT) | ((state_q == EXTRA) & built_q);
    assign blk_take  = blk_vld & blk_rdy;
    assign blk_first = (state_q == EMIT) & first_q;
    assign blk_final = ((state_q == EMIT) & final_q) | ((state_q == EXTRA) & built_q);

    // Mask unused bytes, insert the 0x80 marker, and compute the running bit length.
    always_comb begin
        nb_eff    = (in_nbytes > 3'd4) ? 3'd4 : in_nbytes;
        byte_mask = 32'hFFFF_FFFF;
        marker    = 32'h0;
        case (nb_eff)
            3'd0: begin byte_mask = 32'h0000_0000; marker = 32'h8000_0000; end
            3'd1: begin byte_mask = 32'hFF00_0000; marker = 32'h0080_0000; end
            3'd2: begin byte_mask = 32'hFFFF_0000; marker = 32'h0000_8000; end
            3'd3: begin byte_mask = 32'hFFFF_FF00; marker = 32'h0000_0080; end
            default: begin byte_mask = 32'hFFFF_FFFF; marker = 32'h0; end
        endcase
        if (!in_last) begin
            marker = 32'h0;
        end
        word_wr   = (in_data & byte_mask) | marker;
        bitlen_nx = bitlen_q + LEN_W'({nb_eff, 3'b000});
        len_nx    = 64'(bitlen_nx);
        len_cur   = 64'(bitlen_q);
        // Index of the word that carries the 0x80 marker; 16 means it spills into the extra block.
        p_idx     = (nb_eff == 3'd4) ? ({1'b0, widx_q} + 5'd1) : {1'b0, widx_q};
    end

    // Output ramp: in_rdy stays low until the first clock after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: a block completes on a last word or on word 15; the extra block follows when pending.
    always_comb begin
        state_d = state_q;
        case (state_q)
            FILL:    if (accept && (in_last || (widx_q == 4'd15))) state_d = EMIT;
            EMIT:    if (blk_rdy) state_d = extra_pend_q ? EXTRA : FILL;
            EXTRA:   if (blk_take) state_d = FILL;
            default: state_d = FILL;
        endcase
    end

    // Block buffer, word index, bit length and message flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) blk_q[i] <= '0;
            widx_q       <= '0;
            bitlen_q     <= '0;
            first_q      <= 1'b1;
            final_q      <= 1'b0;
            extra_pend_q <= 1'b0;
            x80_pend_q   <= 1'b0;
            built_q      <= 1'b0;
        end else begin
            case (state_q)
                FILL: begin
                    if (accept) begin
                        blk_q[widx_q] <= word_wr;
                        bitlen_q      <= bitlen_nx;
                        if (in_last) begin
                            // A full last word pushes the marker into the following word.
                            if ((nb_eff == 3'd4) && (p_idx <= 5'd15)) begin
                                blk_q[p_idx[3:0]] <= 32'h8000_0000;
                            end
                            if (p_idx <= 5'd13) begin
                                blk_q[14] <= len_nx[63:32];
                                blk_q[15] <= len_nx[31:0];
                                final_q   <= 1'b1;
                            end else begin
                                final_q      <= 1'b0;
                                extra_pend_q <= 1'b1;
                                x80_pend_q   <= (p_idx == 5'd16);
                            end
                        end else begin
                            final_q <= 1'b0;
                            if (widx_q != 4'd15) begin
                                widx_q <= widx_q + 4'd1;
                            end
                        end
                    end
                end
                EMIT: begin
                    if (blk_rdy) begin
                        for (int i = 0; i < 16; i++) blk_q[i] <= '0;
                        first_q <= 1'b0;
                        if (!extra_pend_q) begin
                            widx_q <= '0;
                            if (final_q) begin
                                bitlen_q <= '0;
                                first_q  <= 1'b1;
                            end
                        end
                    end
                end
                EXTRA: begin
                    if (!built_q) begin
                        // One build cycle: marker (if it spilled over) plus the length words.
                        blk_q[0]  <= x80_pend_q ? 32'h8000_0000 : 32'h0;
                        blk_q[14] <= len_cur[63:32];
                        blk_q[15] <= len_cur[31:0];
                        built_q   <= 1'b1;
                    end else if (blk_take) begin
                        for (int i = 0; i < 16; i++) blk_q[i] <= '0;
                        widx_q       <= '0;
                        bitlen_q     <= '0;
                        first_q      <= 1'b1;
                        final_q      <= 1'b0;
                        extra_pend_q <= 1'b0;
                        x80_pend_q   <= 1'b0;
                        built_q      <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Present words 0..7 and 8..15 with the lowest-numbered word in the top bits.
    always_comb begin
        blk_lo = '0;
        blk_hi = '0;
        for (int i = 0; i < 8; i++) begin
            blk_lo[32*(7-i) +: 32] = blk_q[i];
            blk_hi[32*(7-i) +: 32] = blk_q[i+8];
        end
    end

endmodule

// File: tb/tb_sha_msg_pad.sv
module tb_sha_msg_pad;

    logic         clk;
    logic         rst;
    logic         in_vld;
    logic         in_rdy;
    logic [31:0]  in_data;
    logic [2:0]   in_nbytes;
    logic         in_last;
    logic         blk_vld;
    logic         blk_rdy;
    logic [255:0] blk_lo;
    logic [255:0] blk_hi;
    logic         blk_first;
    logic         blk_final;

    int total;
    int bad;
    logic [31:0] exp_w [16];

    sha_msg_pad #(.LEN_W(64)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_vld    (in_vld),
        .in_rdy    (in_rdy),
        .in_data   (in_data),
        .in_nbytes (in_nbytes),
        .in_last   (in_last),
        .blk_vld   (blk_vld),
        .blk_rdy   (blk_rdy),
        .blk_lo    (blk_lo),
        .blk_hi    (blk_hi),
        .blk_first (blk_first),
        .blk_final (blk_final)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The stimulus must never present an out-of-range byte count.
    always @(posedge clk) begin
        if (in_vld) begin
            total++;
            assert (in_nbytes <= 3'd4) else begin
                bad++;
                $error("FAIL nbytes_legal: observed=%0d expected<=4", in_nbytes);
            end
        end
    end

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic clr_exp();
        for (int i = 0; i < 16; i++) exp_w[i] = 32'h0;
    endtask

    task automatic send(input logic [31:0] d, input logic [2:0] nb, input logic last);
        int n;
        in_vld    = 1'b1;
        in_data   = d;
        in_nbytes = nb;
        in_last   = last;
        n = 0;
        while (!in_rdy && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("send_rdy", in_rdy, 1);
        @(posedge clk); #1;
        in_vld  = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic check_blk(input string tag, input logic ef, input logic efin);
        logic [255:0] el;
        logic [255:0] eh;
        int n;
        n = 0;
        while (!blk_vld && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_vld"}, blk_vld, 1);
        el = '0;
        eh = '0;
        for (int i = 0; i < 8; i++) begin
            el[32*(7-i) +: 32] = exp_w[i];
            eh[32*(7-i) +: 32] = exp_w[i+8];
        end
        check({tag, "_lo"}, blk_lo, el);
        check({tag, "_hi"}, blk_hi, eh);
        check({tag, "_first"}, blk_first, ef);
        check({tag, "_final"}, blk_final, efin);
    endtask

    task automatic take_blk();
        blk_rdy = 1'b1;
        @(posedge clk); #1;
        blk_rdy = 1'b0;
    endtask

    task automatic exp_abc();
        clr_exp();
        exp_w[0]  = 32'h6162_6380;
        exp_w[15] = 32'h0000_0018;
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst       = 1'b1;
        in_vld    = 1'b0;
        in_data   = 32'h0;
        in_nbytes = 3'd0;
        in_last   = 1'b0;
        blk_rdy   = 1'b0;
        clr_exp();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_rdy", in_rdy, 0);
        check("rst_blk_vld", blk_vld, 0);
        check("rst_blk_lo", blk_lo, 0);
        check("rst_blk_hi", blk_hi, 0);
        check("rst_first", blk_first, 0);
        check("rst_final", blk_final, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_in_rdy", in_rdy, 1);

        // "abc": single final block, valid right after the accepting edge
        send(32'h6162_6300, 3'd3, 1'b1);
        check("abc_latency", blk_vld, 1);
        exp_abc();
        check_blk("abc", 1'b1, 1'b1);
        take_blk();
        check("abc_vld_fall", blk_vld, 0);
        check("abc_back_to_fill", in_rdy, 1);

        // Empty message
        send(32'hDEAD_BEEF, 3'd0, 1'b1);
        clr_exp();
        exp_w[0] = 32'h8000_0000;
        check_blk("empty", 1'b1, 1'b1);
        take_blk();

        // Partial last word: garbage bytes must be dropped
        send(32'h4142_4344, 3'd4, 1'b0);
        send(32'h4546_FFFF, 3'd2, 1'b1);
        clr_exp();
        exp_w[0]  = 32'h4142_4344;
        exp_w[1]  = 32'h4546_8000;
        exp_w[15] = 32'h0000_0030;
        check_blk("six_bytes", 1'b1, 1'b1);
        take_blk();

        // 14 full words: marker in word 14, length in an extra block
        for (int i = 0; i < 14; i++) send(32'h1000_0000 + 32'(i), 3'd4, (i == 13));
        clr_exp();
        for (int i = 0; i < 14; i++) exp_w[i] = 32'h1000_0000 + 32'(i);
        exp_w[14] = 32'h8000_0000;
        check_blk("w14_blk1", 1'b1, 1'b0);
        take_blk();
        check("w14_gap", blk_vld, 0);
        clr_exp();
        exp_w[15] = 32'h0000_01C0;
        check_blk("w14_extra", 1'b0, 1'b1);
        take_blk();

        // 15 full words: marker in word 15, extra block has no marker
        for (int i = 0; i < 15; i++) send(32'h2000_0000 + 32'(i), 3'd4, (i == 14));
        clr_exp();
        for (int i = 0; i < 15; i++) exp_w[i] = 32'h2000_0000 + 32'(i);
        exp_w[15] = 32'h8000_0000;
        check_blk("w15_blk1", 1'b1, 1'b0);
        take_blk();
        clr_exp();
        exp_w[15] = 32'h0000_01E0;
        check_blk("w15_extra", 1'b0, 1'b1);
        take_blk();

        // 16 full words: marker spills into the extra block
        for (int i = 0; i < 16; i++) send(32'h3000_0000 + 32'(i), 3'd4, (i == 15));
        clr_exp();
        for (int i = 0; i < 16; i++) exp_w[i] = 32'h3000_0000 + 32'(i);
        check_blk("w16_blk1", 1'b1, 1'b0);
        take_blk();
        clr_exp();
        exp_w[0]  = 32'h8000_0000;
        exp_w[15] = 32'h0000_0200;
        check_blk("w16_extra", 1'b0, 1'b1);
        take_blk();

        // Backpressure: held block stays stable and ignores input pulses
        send(32'h6162_6300, 3'd3, 1'b1);
        exp_abc();
        check_blk("bp_start", 1'b1, 1'b1);
        for (int c = 0; c < 20; c++) begin
            in_vld    = c[0];
            in_data   = 32'hA5A5_0000 + 32'(c);
            in_nbytes = 3'd4;
            @(posedge clk); #1;
            check("bp_vld", blk_vld, 1);
            check("bp_in_rdy", in_rdy, 0);
            check("bp_lo", blk_lo, 256'h6162_6380 << 224);
        end
        in_vld = 1'b0;
        check_blk("bp_end", 1'b1, 1'b1);
        take_blk();
        check("bp_fill_next", in_rdy, 1);
        send(32'h6162_6300, 3'd3, 1'b1);
        exp_abc();
        check_blk("bp_after", 1'b1, 1'b1);

        // Reset while a block is held drops blk_vld without a clock
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_vld", blk_vld, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Reset after 5 words of a 2-block message, then "abc"
        for (int i = 0; i < 5; i++) send(32'h4000_0000 + 32'(i), 3'd4, 1'b0);
        check("mid_no_vld", blk_vld, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        send(32'h6162_6300, 3'd3, 1'b1);
        exp_abc();
        check_blk("abc_after_rst", 1'b1, 1'b1);
        take_blk();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
